pipe_stage_buf: RTL

- Parametrised inter-stage buffer for the multi-cycle/pipelined LoongArch core. It replaces the single implicit state register between IF/ID/EXE/MEM/WB.
- Holds up to DEPTH in-flight payloads of WIDTH bits, using the valid/allowin handshake on both sides.
- Adds features the single-cycle datapath lacks: a stage-local ready_go gate, a flush for branch redirect/exception, and an occupancy output for hazard logic.

---
 rtl/pipe_stage_buf.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage buffer for the pipelined core.
// Holds up to DEPTH payloads. Both sides use a valid/allowin handshake.
// Adds a stage-local ready_go gate, a flush for redirects, and an
// occupancy count for the hazard logic.
//
// Ports:
//   clk, resetn   rising-edge clock; asynchronous active-low reset
//   in_valid      upstream presents in_data
//   in_data       upstream payload (WIDTH bits)
//   in_allowin    buffer accepts a payload this cycle (registered state only)
//   out_valid     head payload presented downstream (gated by ready_go)
//   out_data      head payload, mem[rd_ptr] at all times
//   out_allowin   downstream accepts this cycle
//   ready_go      stage-local completion; head may leave only when 1
//   flush         discard all held payloads
//   occupancy     number of valid entries held
module pipe_stage_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_allowin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_allowin,
  input  logic             ready_go,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake outputs: in_allowin depends only on the count register.
  always_comb begin
    in_allowin = (count_q != FULL_CNT);
    out_valid  = (count_q != '0) & ready_go;
    out_data   = mem_q[rd_ptr_q];
    occupancy  = count_q;
    push       = in_valid & in_allowin;
    pop        = out_valid & out_allowin;
  end

  // Next-state: flush wins over push/pop and leaves storage untouched.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
